// File: rtl/aes_pkg.sv
// Shared AES-128 constants and GF(2^8) helpers for the encrypt core.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_NR    = 10;
    localparam int AES_RK_W  = 1408;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } aes_fsm_e;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column; bits [31:24] hold row 0.
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction

    // Round key r sits in the top-most slice for r=0, lowest for r=10.
    function automatic logic [AES_BLK_W-1:0] round_key(input logic [AES_RK_W-1:0] w,
                                                        input logic [3:0]          r);
        int sh;
        sh = AES_BLK_W * (AES_NR - int'(r));
        return AES_BLK_W'(w >> sh);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. Purely combinational.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // Inverse as a^254 = product of a^2, a^4 .. a^128 (maps 0 to 0), then affine map.
    always_comb begin
        sq  = a_i;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        s_o = inv
            ^ {inv[6:0], inv[7]}
            ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]}
            ^ 8'h63;
    end

endmodule

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 cipher, one round per clock, 11 cycles per block.
// Optional simulation trace of each round: define AES_ENC_ROUND_TRACE_EN.
module aes128_encrypt_core
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AES_BLK_W-1:0] in,
    input  logic [AES_RK_W-1:0]  w,
    output logic [AES_BLK_W-1:0] out,
    output logic                 busy,
    output logic                 done
);

    aes_fsm_e             fsm_q;
    logic [3:0]           rnd_q;
    logic [AES_BLK_W-1:0] state_q;
    logic [AES_BLK_W-1:0] state_d;
    logic [AES_BLK_W-1:0] out_q;
    logic                 busy_q;
    logic                 done_q;

    logic [7:0]           sb_b [16];
    logic [AES_BLK_W-1:0] sr_w;
    logic [AES_BLK_W-1:0] mc_w;
    logic [AES_BLK_W-1:0] rk_w;
    logic                 last_rnd;

    // SubBytes on every state byte, with ShiftRows folded into the output wiring.
    // Byte i is row i%4, column i/4; row k takes its byte from column c+k.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        aes_sbox u_sbox (
            .a_i (state_q[AES_BLK_W-1-8*gi -: 8]),
            .s_o (sb_b[gi])
        );
        assign sr_w[AES_BLK_W-1-8*gi -: 8] = sb_b[(gi % 4) + 4 * (((gi / 4) + (gi % 4)) % 4)];
    end

    for (genvar gc = 0; gc < 4; gc++) begin : g_col
        assign mc_w[AES_BLK_W-1-32*gc -: 32] = mix_column(sr_w[AES_BLK_W-1-32*gc -: 32]);
    end

    // The counter is 0 while idle, so the same slice select yields the initial key.
    assign rk_w     = round_key(w, rnd_q);
    assign last_rnd = (rnd_q == 4'(AES_NR));

    // Next state: initial AddRoundKey when idle, otherwise one full round.
    always_comb begin
        state_d = '0;
        if (fsm_q == ST_IDLE) begin
            state_d = in ^ rk_w;
        end else if (last_rnd) begin
            state_d = sr_w ^ rk_w;
        end else begin
            state_d = mc_w ^ rk_w;
        end
    end

    // Control FSM with round counter, state register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= ST_IDLE;
            rnd_q   <= 4'd0;
            state_q <= '0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= state_d;
                        rnd_q   <= 4'd1;
                        busy_q  <= 1'b1;
                        fsm_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_q <= state_d;
                    if (last_rnd) begin
                        out_q  <= state_d;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        rnd_q  <= 4'd0;
                        fsm_q  <= ST_IDLE;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                default: begin
                    fsm_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

`ifdef AES_ENC_ROUND_TRACE_EN
    // Print each round result and the final ciphertext as it is committed.
    always_ff @(posedge clk) begin
        if (!rst && fsm_q == ST_RUN) begin
            $display("aes_enc round %0d state %032h", rnd_q, state_d);
            if (last_rnd) begin
                $display("aes_enc ciphertext %032h", state_d);
            end
        end
    end
`else
    // Trace disabled: no extra logic in this build.
`endif

endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Self-checking bench for aes128_encrypt_core: FIPS-197 vectors, reset/abort,
// start-while-busy, back-to-back and random blocks against a byte-level model.
module tb_aes128_encrypt_core;
    import aes_pkg::*;

    logic            clk;
    logic            rst;
    logic            start;
    logic [127:0]    blk_in;
    logic [1407:0]   rk_in;
    logic [127:0]    ct_out;
    logic            busy;
    logic            done;

    int n_chk;
    int n_fail;

    logic [7:0]    sbox_t [256];
    logic [2047:0] sbox_flat;

    aes128_encrypt_core dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (blk_in),
        .w     (rk_in),
        .out   (ct_out),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul2(input logic [7:0] b);
        logic [8:0] t;
        t = {b, 1'b0};
        if (t[8]) t = t ^ 9'h11b;
        return t[7:0];
    endfunction

    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0]   wd [44];
        logic [31:0]   tmp;
        logic [7:0]    rc;
        logic [1407:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) wd[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = wd[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]};
                tmp = tmp ^ {rc, 24'h0};
                rc  = gmul2(rc);
            end
            wd[i] = wd[i-4] ^ tmp;
        end
        for (int i = 0; i < 44; i++) res[1407-32*i -: 32] = wd[i];
        return res;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [1407:0] rk);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[1407-8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    t[row + 4*col] = s[row + 4*((col + row) % 4)];
            for (int col = 0; col < 4; col++) begin
                a0 = t[4*col]; a1 = t[4*col+1]; a2 = t[4*col+2]; a3 = t[4*col+3];
                if (r < 10) begin
                    s[4*col]   = gmul2(a0) ^ gmul2(a1) ^ a1 ^ a2 ^ a3;
                    s[4*col+1] = a0 ^ gmul2(a1) ^ gmul2(a2) ^ a2 ^ a3;
                    s[4*col+2] = a0 ^ a1 ^ gmul2(a2) ^ gmul2(a3) ^ a3;
                    s[4*col+3] = gmul2(a0) ^ a0 ^ a1 ^ a2 ^ gmul2(a3);
                end else begin
                    s[4*col] = a0; s[4*col+1] = a1; s[4*col+2] = a2; s[4*col+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[1407-128*r-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic run_block(input string tag, input logic [127:0] pt,
                             input logic [1407:0] rk, input logic [127:0] exp);
        int lat;
        lat = 0;
        @(negedge clk);
        blk_in = pt;
        rk_in  = rk;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy_e0"}, {127'd0, busy}, 128'd1);
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (done) lat = k;
        end
        chk({tag, "_latency"}, 128'(lat), 128'd10);
        chk({tag, "_out"}, ct_out, exp);
        chk({tag, "_busy_end"}, {127'd0, busy}, 128'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_width"}, {127'd0, done}, 128'd0);
        chk({tag, "_out_hold"}, ct_out, exp);
    endtask

    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1407:0] w_c1;
        logic [1407:0] w_b;
        logic [1407:0] w_r;
        logic [127:0]  key_r;
        logic [127:0]  pt_r;
        int            n_done;
        int            t_done;
        int            t1;
        int            t2;

        n_chk  = 0;
        n_fail = 0;
        sbox_flat = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_flat[2047-8*i -: 8];

        w_c1 = expand_key(C1_KEY);
        w_b  = expand_key(B_KEY);

        // Reset state
        rst    = 1'b1;
        start  = 1'b0;
        blk_in = '0;
        rk_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", ct_out, 128'd0);
        chk("rst_busy_done", {126'd0, busy, done}, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        // Package slice function and reference model sanity
        chk("rk10_slice", round_key(w_c1, 4'd10), C1_RK10);
        chk("model_c1", aes_ref(C1_PT, w_c1), C1_CT);

        // Known-answer vectors
        run_block("c1", C1_PT, w_c1, C1_CT);
        run_block("appb", B_PT, w_b, B_CT);

        // Asynchronous reset mid-clock while running
        @(negedge clk);
        blk_in = C1_PT; rk_in = w_c1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_out", ct_out, 128'd0);
        chk("async_rst_busy_done", {126'd0, busy, done}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        run_block("c1_after_rst", C1_PT, w_c1, C1_CT);

        // Abort in round 5: no done, out cleared
        @(negedge clk);
        blk_in = C1_PT; rk_in = w_c1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("abort_no_done", 128'(n_done), 128'd0);
        chk("abort_out", ct_out, 128'd0);
        run_block("c1_restart", C1_PT, w_c1, C1_CT);

        // Start while busy at rounds 3 and 10 with another plaintext
        @(negedge clk);
        blk_in = C1_PT; rk_in = w_c1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        n_done = 0;
        t_done = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            start  = (k == 3 || k == 10);
            blk_in = (k == 3 || k == 10) ? B_PT : C1_PT;
            @(posedge clk); #1;
            if (done) begin
                n_done++;
                t_done = k;
            end
        end
        start = 1'b0;
        chk("busy_start_ndone", 128'(n_done), 128'd1);
        chk("busy_start_tdone", 128'(t_done), 128'd10);
        chk("busy_start_out_held", ct_out, C1_CT);
        chk("busy_start_idle", {127'd0, busy}, 128'd0);

        // Back-to-back with start held high
        @(negedge clk);
        blk_in = C1_PT; rk_in = w_c1; start = 1'b1;
        @(posedge clk); #1;
        t1 = 0;
        t2 = 0;
        for (int k = 1; k <= 40 && t2 == 0; k++) begin
            @(posedge clk); #1;
            if (k == 11) start = 1'b0;
            if (done) begin
                if (t1 == 0) begin
                    t1 = k;
                    chk("b2b_first_out", ct_out, C1_CT);
                    blk_in = B_PT;
                    rk_in  = w_b;
                end else begin
                    t2 = k;
                    chk("b2b_second_out", ct_out, B_CT);
                end
            end
        end
        start = 1'b0;
        chk("b2b_first_t", 128'(t1), 128'd10);
        chk("b2b_spacing", 128'(t2 - t1), 128'd11);

        // Random keys and plaintexts against the model
        for (int n = 0; n < 16; n++) begin
            key_r = {$urandom, $urandom, $urandom, $urandom};
            pt_r  = {$urandom, $urandom, $urandom, $urandom};
            w_r   = expand_key(key_r);
            run_block($sformatf("rand%0d", n), pt_r, w_r, aes_ref(pt_r, w_r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/aes128_encrypt_core.md
# aes128_encrypt_core

Iterative AES-128 encryption datapath (FIPS-197 Cipher) that turns one 128-bit plaintext block into ciphertext using a precomputed, flattened round-key schedule. It executes one round per clock. It sits downstream of the key-expansion block, which supplies the 11 round keys, and alongside the decipher block, which consumes its ciphertext. Key expansion and decryption are outside this block.

## Interface
Parameters:
- none; all sizes are fixed constants from the shared package.

Ports:
- `clk` input 1: single clock, rising-edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request to encrypt `in` with `w`; sampled only while idle.
- `in` input 128: plaintext. Byte 0 of the state is `in[127:120]`, and bytes fill column-major per FIPS-197.
- `w` input 1408: round keys. Round key r (0..10) is `w[1407-128*r -: 128]`, so round key 0 (the cipher key) is `w[1407:1280]`. Byte order is the same as `in`.
- `out` output 128: ciphertext register, same byte order; holds its value until the next completion.
- `busy` output 1: high while rounds are in progress.
- `done` output 1: one-cycle pulse when `out` is updated.

## Operation
- Idle with `start`=1: load state ← `in` XOR round key 0, round counter ← 1, `busy` ← 1.
- Rounds 1..9, one per cycle: state ← AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), round key r). Then increment the counter.
- Round 10: same, but MixColumns is omitted. The result is written to `out`, `done` pulses, `busy` ← 0, counter ← 0.
- MixColumns is over GF(2^8) with polynomial 0x11B. xtime(b) = (b<<1) XOR (0x1B if b[7]). The column matrix is [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
- ShiftRows rotates row k left by k bytes, where row k is bytes k, k+4, k+8, k+12.
- `start` while `busy`=1 is ignored. `in` and `w` are not captured; they must stay stable from the start cycle through completion.
- The FSM has two states. IDLE goes to RUN on `start`. RUN goes to IDLE after round 10. There is no other state.

## Timing
- Reset values: `out`=0, `done`=0, `busy`=0, state=0, counter=0.
- Latency: for `start` sampled at rising edge E0, `out` and `done` update at edge E10. `done` is high for exactly the cycle E10..E11.
- `busy` is high from E0 to E10. A new `start` is accepted at E11 at the earliest, so throughput is one block per 11 cycles.
- Back-to-back `start` held high gives a result every 11 cycles.
- `rst` asserted mid-operation aborts immediately. All registers, including `out`, return to reset values, and no `done` is produced.
- `out` is stable whenever `busy`=0.

## Configuration
- `AES_ENC_ROUND_TRACE_EN` defined: simulation-only `$display` of the round number and the 128-bit state after each round, plus the final ciphertext. It is excluded from synthesis.
- Not defined: no trace code is generated. Functional behaviour is identical in both cases.

## Structure
- Package `aes_pkg` holds:
  - the constants `AES_BLK_W`=128, `AES_NR`=10, `AES_RK_W`=1408;
  - the function `xtime`;
  - the function `mix_column` (32-bit in and out);
  - the function `round_key(w, r)` for slicing.
- Sub-module `aes_sbox` is combinational, 8 bits in and 8 bits out, implementing the forward S-box. It is instantiated 16 times.
- The top holds the FSM, round counter, state register, ShiftRows wiring, MixColumns and AddRoundKey.

## Test plan
- FIPS-197 C.1: `in`=00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f expanded by the existing key-expansion block. Pulse `start`. Require `done` at E10 with `out`=69c4e0d86a7b0430d8cdb78070b4c55a, and round key 10 slice = 13111d7fe3944a17f307a78b4d2b30c5.
- FIPS-197 Appendix B: `in`=3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c. Require `out`=3925841d02dc09fbdc118597196a0b32.
- Reset: assert `rst` asynchronously mid-clock. Require `out`=0, `busy`=0 and `done`=0 immediately. Then run the C.1 vector to completion.
- Abort: assert `rst` at round 5 of C.1. Require no `done` and `out`=0. A restart then yields 69c4e0d8….
- Start while busy: pulse `start` again at rounds 3 and 10 with a different `in`. Require it is ignored: one `done` with the C.1 result, and `out` is held afterwards.
- Back-to-back: hold `start`=1 through the C.1 then Appendix B vectors. Require `done` pulses 11 cycles apart with the correct ciphertexts in order.
